aes_core_ctrl: RTL and testbench
================================

# aes_core_ctrl

Initiator-side controller that drives the ld/kld/done/kdone handshake of one AES-128 core (cipher or inverse cipher) from valid/ready block streams. It accepts a key and a stream of 128-bit blocks, pulses the core's load strobes, waits for completion, and presents results on an output stream. It sits between the system datapath and one `aes_cipher_top` or `aes_inv_cipher_top` instance, one controller per core.

## Interface
- `DECRYPT`, 0: 0 drives a cipher core (no key expansion); 1 drives an inverse-cipher core (kld/kdone sequence required).
- `TIMEOUT_CYC`, 64: maximum cycles to wait for `core_done`/`core_kdone` before erroring.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: **synchronous, active-high** reset.
- `key_in` in 128: key, captured on the key handshake.
- `key_valid` in 1 / `key_ready` out 1: key handshake.
- `in_data` in 128 / `in_valid` in 1 / `in_ready` out 1: input block stream.
- `out_data` out 128 / `out_valid` out 1 / `out_ready` in 1: output block stream.
- `core_ld` out 1, `core_kld` out 1, `core_key` out 128, `core_text_in` out 128: core drive.
- `core_text_out` in 128, `core_done` in 1, `core_kdone` in 1: core response.
- `busy` out 1: state is not IDLE or READY.
- `err` out 1: sticky timeout flag.

## Operation
- States: IDLE (no key) → KEXP (DECRYPT=1 only) → READY → LOAD → BUSY → OUT → READY.
- IDLE: `key_ready`=1, `in_ready`=0. Key handshake latches `key_reg`, clears `err`, then goes to KEXP if DECRYPT=1, else READY.
- KEXP: `core_kld`=1 for the first cycle only. Waits for `core_kdone`=1, then goes to READY.
- READY: `key_ready`=1 and `in_ready`=1. If `key_valid` and `in_valid` are both high, the key wins and `in_ready` is forced to 0 that cycle; the re-key path matches IDLE. An input handshake latches `blk_reg` and goes to LOAD.
- LOAD: `core_ld`=1 for exactly one cycle, then goes to BUSY.
- BUSY: waits for `core_done`=1. On that cycle, captures `core_text_out` into `out_reg` and goes to OUT.
- OUT: `out_valid`=1 and `out_data`=`out_reg`, both held until `out_ready`. Handshake then goes to READY. No input is accepted in OUT.
- `core_key`=`key_reg` and `core_text_in`=`blk_reg` at all times. Both are stable from LOAD through the end of BUSY.
- `core_done` outside BUSY and `core_kdone` outside KEXP are ignored.
- Watchdog: a counter runs in KEXP and BUSY and clears on state entry. When it reaches TIMEOUT_CYC, `err` is set and the state goes to IDLE (key invalidated, block dropped).
- Reset mid-operation: the state goes to IDLE immediately, the pending block is discarded, and a late `core_done` is ignored.

## Timing
- Reset values: `key_ready`=0 during rst (1 from the first IDLE cycle), `in_ready`=0, `out_valid`=0, `out_data`=0, `core_ld`=0, `core_kld`=0, `core_key`=0, `core_text_in`=0, `busy`=0, `err`=0.
- Input handshake at cycle N: `core_ld` is high at N+1, BUSY starts at N+2.
- `core_done` at cycle M: `out_valid`=1 at M+1.
- Latency from input handshake to `out_valid` = 2 + core latency. The earliest next `in_ready` is the cycle after the output handshake.
- `err` rises the cycle after the count hits TIMEOUT_CYC. It stays high until rst or the next key handshake.

## Configuration
- `AES_CTRL_CBC_EN` defined: CBC chaining. `iv_reg` is loaded with `key_in` bits reversed? No: it is loaded with a separate `iv_in` [127:0] port captured on the key handshake (the port exists only with the macro).
  - Encrypt: `core_text_in` = `blk_reg ^ iv_reg`, and `iv_reg` ← ciphertext at capture.
  - Decrypt: `out_reg` = `core_text_out ^ iv_reg`, and `iv_reg` ← `blk_reg` at capture.
  - A timeout or reset clears `iv_reg` to 0.
- `AES_CTRL_CBC_EN` undefined: ECB. No `iv_in` port, no XOR, no `iv_reg`.

## Structure
- `aes_ctrl_pkg`: state enum `aes_ctrl_state_e`, `AES_BLK_W`=128, `AES_KEY_W`=128, and the timeout counter width function `$clog2(TIMEOUT_CYC+1)`.
- One sub-module, `aes_ctrl_wdog`: inputs clear and run; output expire.

## Test plan
- Reset release: all outputs match the reset values, then `key_ready`=1 and `in_ready`=0.
- DECRYPT=0: key 000102…0f, block 00112233445566778899aabbccddeeff. Required: one `core_ld` pulse, then `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a.
- DECRYPT=1: same key. Required: `core_kld` pulse, wait for kdone. Block 69c4e0d8…c55a must return 00112233…eeff.
- Backpressure: hold `out_ready`=0 for 20 cycles. Required: `out_data` stable, `in_ready`=0 throughout, exactly one output.
- Core stub never asserts done with TIMEOUT_CYC=64. Required: `err`=1 at handshake+66, state IDLE. A new key handshake clears `err`.
- Simultaneous key and in valid in READY: the key is taken and the block is not consumed. Then rst asserted during BUSY: no `out_valid`, and a late done is ignored.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared types and widths for the AES core handshake controller.
//   aes_ctrl_state_e : controller state encoding
//   AES_BLK_W/KEY_W  : block and key widths
//   wdog_cnt_w()     : watchdog counter width for a given timeout
package aes_ctrl_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES_KEY_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEXP  = 3'd1,
    ST_READY = 3'd2,
    ST_LOAD  = 3'd3,
    ST_BUSY  = 3'd4,
    ST_OUT   = 3'd5
  } aes_ctrl_state_e;

  // Counter must be able to hold TIMEOUT_CYC; never narrower than one bit.
  function automatic int unsigned wdog_cnt_w(input int unsigned timeout_cyc);
    int unsigned w;
    w = $clog2(timeout_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/aes_ctrl_wdog.sv
// aes_ctrl_wdog: cycle watchdog for the core wait states.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count (asserted on state change)
//   run      : count this cycle (controller is waiting on the core)
//   expire   : high in the TIMEOUT_CYC-th consecutive running cycle
module aes_ctrl_wdog
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int unsigned CNT_W = wdog_cnt_w(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // cnt_q is the number of cycles already spent waiting in the current state.
  assign expire = run && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_core_ctrl.sv
// aes_core_ctrl: drives the ld/kld/done/kdone handshake of one AES-128 core
// from valid/ready key, input and output block streams.
//   clk, rst                       : clock, synchronous active-high reset
//   key_in/key_valid/key_ready     : key stream (re-key allowed when idle/ready)
//   iv_in                          : CBC initial vector (AES_CTRL_CBC_EN only)
//   in_data/in_valid/in_ready      : input block stream
//   out_data/out_valid/out_ready   : result block stream
//   core_ld/core_kld/core_key/core_text_in       : core drive
//   core_text_out/core_done/core_kdone           : core response
//   busy                           : a block or key expansion is in flight
//   err                            : sticky core timeout flag
// Build option: define AES_CTRL_CBC_EN for CBC chaining; ECB otherwise.
module aes_core_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter bit          DECRYPT     = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic                 key_valid,
  output logic                 key_ready,
`ifdef AES_CTRL_CBC_EN
  input  logic [AES_BLK_W-1:0] iv_in,
`endif
  input  logic [AES_BLK_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 core_ld,
  output logic                 core_kld,
  output logic [AES_KEY_W-1:0] core_key,
  output logic [AES_BLK_W-1:0] core_text_in,
  input  logic [AES_BLK_W-1:0] core_text_out,
  input  logic                 core_done,
  input  logic                 core_kdone,
  output logic                 busy,
  output logic                 err
);

  aes_ctrl_state_e      state_q, state_d;
  logic [AES_KEY_W-1:0] key_q, key_d;
  logic [AES_BLK_W-1:0] blk_q, blk_d;
  logic [AES_BLK_W-1:0] out_q, out_d;
  logic                 err_q, err_d;
  logic                 core_ld_q, core_ld_d;
  logic                 core_kld_q, core_kld_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
`ifdef AES_CTRL_CBC_EN
  logic [AES_BLK_W-1:0] iv_q, iv_d;
`endif

  logic key_open;
  logic key_acc;
  logic in_acc;
  logic wdog_clear;
  logic wdog_run;
  logic wdog_expire;

  // Key is accepted in IDLE and READY; a pending key blocks the input stream.
  assign key_open  = (state_q == ST_IDLE) || (state_q == ST_READY);
  assign key_acc   = key_valid && key_open;
  assign in_acc    = in_valid && (state_q == ST_READY) && !key_valid;
  assign key_ready = !rst && key_open;
  assign in_ready  = !rst && (state_q == ST_READY) && !key_valid;

  // Count restarts on every state entry and only advances while waiting on the core.
  assign wdog_clear = (state_d != state_q);
  assign wdog_run   = (state_q == ST_KEXP) || (state_q == ST_BUSY);

  aes_ctrl_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clear (wdog_clear),
    .run   (wdog_run),
    .expire(wdog_expire)
  );

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    blk_d   = blk_q;
    out_d   = out_q;
    err_d   = err_q;
`ifdef AES_CTRL_CBC_EN
    iv_d    = iv_q;
`endif

    if (key_acc) begin
      key_d   = key_in;
      err_d   = 1'b0;
`ifdef AES_CTRL_CBC_EN
      iv_d    = iv_in;
`endif
      state_d = DECRYPT ? ST_KEXP : ST_READY;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_KEXP: begin
          if (core_kdone) begin
            state_d = ST_READY;
          end else if (wdog_expire) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
`ifdef AES_CTRL_CBC_EN
            iv_d    = '0;
`endif
          end
        end
        ST_READY: begin
          if (in_acc) begin
            blk_d   = in_data;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: state_d = ST_BUSY;
        ST_BUSY: begin
          // A done in the expiry cycle still completes the block.
          if (core_done) begin
`ifdef AES_CTRL_CBC_EN
            if (DECRYPT) begin
              out_d = core_text_out ^ iv_q;
              iv_d  = blk_q;
            end else begin
              out_d = core_text_out;
              iv_d  = core_text_out;
            end
`else
            out_d = core_text_out;
`endif
            state_d = ST_OUT;
          end else if (wdog_expire) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
`ifdef AES_CTRL_CBC_EN
            iv_d    = '0;
`endif
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_d = ST_READY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Strobes and status are registered off the next state.
    core_ld_d   = (state_d == ST_LOAD);
    core_kld_d  = (state_d == ST_KEXP) && (state_q != ST_KEXP);
    out_valid_d = (state_d == ST_OUT);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      blk_q       <= '0;
      out_q       <= '0;
      err_q       <= 1'b0;
      core_ld_q   <= 1'b0;
      core_kld_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AES_CTRL_CBC_EN
      iv_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      blk_q       <= blk_d;
      out_q       <= out_d;
      err_q       <= err_d;
      core_ld_q   <= core_ld_d;
      core_kld_q  <= core_kld_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef AES_CTRL_CBC_EN
      iv_q        <= iv_d;
`endif
    end
  end

  assign core_key  = key_q;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign core_ld   = core_ld_q;
  assign core_kld  = core_kld_q;
  assign busy      = busy_q;
  assign err       = err_q;

`ifdef AES_CTRL_CBC_EN
  // iv_q is stable from LOAD through BUSY, so the XOR is stable too.
  assign core_text_in = DECRYPT ? blk_q : (blk_q ^ iv_q);
`else
  assign core_text_in = blk_q;
`endif

endmodule

// File: tb/tb_aes_core_ctrl.sv
// tb_aes_core_ctrl: drives one cipher-side (index 0) and one inverse-side
// (index 1) controller against behavioural core stubs, with a scoreboard
// of (key, block) -> expected result per accepted block.
module tb_aes_core_ctrl;

  localparam int unsigned TO = 64;
  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam int S_KRDY = 0;
  localparam int S_IRDY = 1;
  localparam int S_OUTV = 2;
  localparam int S_ERR  = 3;

  logic clk = 1'b0;
  logic rst;

  logic [127:0] key_in [2];
  logic         key_valid [2];
  logic         key_ready [2];
  logic [127:0] in_data [2];
  logic         in_valid [2];
  logic         in_ready [2];
  logic [127:0] out_data [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic         core_ld [2];
  logic         core_kld [2];
  logic [127:0] core_key [2];
  logic [127:0] core_text_in [2];
  logic [127:0] core_text_out [2];
  logic         core_done [2];
  logic         core_kdone [2];
  logic         busy [2];
  logic         err [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Core stub state
  int           st_cnt [2];
  int           kd_cnt [2];
  int           lat [2];
  bit           hang [2];
  logic [127:0] st_key [2];
  logic [127:0] st_txt [2];
  logic [127:0] key_cur [2];

  always #5 clk = ~clk;

  aes_core_ctrl #(.DECRYPT(1'b0), .TIMEOUT_CYC(TO)) u_enc (
    .clk(clk), .rst(rst),
    .key_in(key_in[0]), .key_valid(key_valid[0]), .key_ready(key_ready[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .core_ld(core_ld[0]), .core_kld(core_kld[0]), .core_key(core_key[0]),
    .core_text_in(core_text_in[0]), .core_text_out(core_text_out[0]),
    .core_done(core_done[0]), .core_kdone(core_kdone[0]),
    .busy(busy[0]), .err(err[0])
  );

  aes_core_ctrl #(.DECRYPT(1'b1), .TIMEOUT_CYC(TO)) u_dec (
    .clk(clk), .rst(rst),
    .key_in(key_in[1]), .key_valid(key_valid[1]), .key_ready(key_ready[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .core_ld(core_ld[1]), .core_kld(core_kld[1]), .core_key(core_key[1]),
    .core_text_in(core_text_in[1]), .core_text_out(core_text_out[1]),
    .core_done(core_done[1]), .core_kdone(core_kdone[1]),
    .busy(busy[1]), .err(err[1])
  );

  // Behavioural AES stand-in: the FIPS-197 vector pair, otherwise an
  // invertible key-dependent mix.
  function automatic logic [127:0] ref_core(input logic [127:0] k, input logic [127:0] t,
                                            input bit dec);
    if (k == KEY0 && !dec && t == PT0) return CT0;
    if (k == KEY0 && dec && t == CT0) return PT0;
    return t ^ {k[63:0], k[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic pick(input int d, input int s);
    case (s)
      S_KRDY:  return key_ready[d];
      S_IRDY:  return in_ready[d];
      S_OUTV:  return out_valid[d];
      default: return err[d];
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Core stubs: done after lat[d] cycles from an observed ld, kdone 3 cycles after kld.
  task automatic stub_tick();
    for (int d = 0; d < 2; d++) begin
      core_done[d]     = 1'b0;
      core_kdone[d]    = 1'b0;
      core_text_out[d] = rand128();
      if (st_cnt[d] > 0) begin
        st_cnt[d]--;
        if (st_cnt[d] == 0 && !hang[d]) begin
          core_done[d]     = 1'b1;
          core_text_out[d] = ref_core(st_key[d], st_txt[d], d == 1);
        end
      end
      if (core_ld[d]) begin
        st_cnt[d] = lat[d];
        st_key[d] = core_key[d];
        st_txt[d] = core_text_in[d];
      end
      if (kd_cnt[d] > 0) begin
        kd_cnt[d]--;
        if (kd_cnt[d] == 0) core_kdone[d] = 1'b1;
      end
      if (core_kld[d]) kd_cnt[d] = 3;
    end
  endtask

  // Advance one cycle; sample point is just after the falling edge.
  task automatic step();
    @(negedge clk);
    stub_tick();
    #1;
    cyc++;
  endtask

  task automatic wait_for(input int d, input int s, input string tag);
    int n;
    n = 0;
    #1;
    while (!pick(d, s) && n < 200) begin
      step();
      n++;
    end
    check_eq(tag, 128'(pick(d, s)), 128'(1));
  endtask

  task automatic load_key(input int d, input logic [127:0] k);
    key_in[d]    = k;
    key_valid[d] = 1'b1;
    wait_for(d, S_KRDY, "key_ready_wait");
    step();
    key_valid[d] = 1'b0;
    key_cur[d]   = k;
    check_eq("err_clear", 128'(err[d]), 128'(0));
    check_eq("core_key", core_key[d], k);
    if (d == 1) begin
      check_eq("kld_pulse", 128'(core_kld[d]), 128'(1));
      check_eq("kexp_in_rdy", 128'(in_ready[d]), 128'(0));
      step();
      check_eq("kld_once", 128'(core_kld[d]), 128'(0));
    end
    wait_for(d, S_IRDY, "ready_after_key");
  endtask

  task automatic xfer(input int d, input logic [127:0] blk, input int l, input int hold);
    int c;
    logic [127:0] exp;
    lat[d]      = l;
    in_data[d]  = blk;
    in_valid[d] = 1'b1;
    wait_for(d, S_IRDY, "in_ready_wait");
    c   = cyc;
    exp = ref_core(key_cur[d], blk, d == 1);
    step();
    in_data[d] = rand128();
    check_eq("ld_pulse", 128'(core_ld[d]), 128'(1));
    check_eq("text_in", core_text_in[d], blk);
    check_eq("busy", 128'(busy[d]), 128'(1));
    step();
    check_eq("ld_single", 128'(core_ld[d]), 128'(0));
    wait_for(d, S_OUTV, "out_valid_wait");
    check_eq("latency", 128'(cyc - c), 128'(2 + l));
    check_eq("out_data", out_data[d], exp);
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq("bp_valid", 128'(out_valid[d]), 128'(1));
      check_eq("bp_data", out_data[d], exp);
      check_eq("bp_in_ready", 128'(in_ready[d]), 128'(0));
      check_eq("bp_no_ld", 128'(core_ld[d]), 128'(0));
    end
    out_ready[d] = 1'b1;
    step();
    out_ready[d] = 1'b0;
    in_valid[d]  = 1'b0;
    check_eq("single_out", 128'(out_valid[d]), 128'(0));
    check_eq("next_in_ready", 128'(in_ready[d]), 128'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout cycle %0d", cyc);
    $fatal(1, "bench did not complete");
  end

  initial begin
    int c;
    logic [127:0] k2, b2;
    bit seen;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      key_in[d] = '0; key_valid[d] = 1'b0; in_data[d] = '0; in_valid[d] = 1'b0;
      out_ready[d] = 1'b0; core_text_out[d] = '0; core_done[d] = 1'b0;
      core_kdone[d] = 1'b0; st_cnt[d] = 0; kd_cnt[d] = 0; lat[d] = 1;
      hang[d] = 1'b0; st_key[d] = '0; st_txt[d] = '0; key_cur[d] = '0;
    end
    repeat (3) step();

    // Reset values
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_key_ready", 128'(key_ready[d]), 128'(0));
      check_eq("rst_in_ready", 128'(in_ready[d]), 128'(0));
      check_eq("rst_out_valid", 128'(out_valid[d]), 128'(0));
      check_eq("rst_out_data", out_data[d], 128'(0));
      check_eq("rst_core_ld", 128'(core_ld[d]), 128'(0));
      check_eq("rst_core_kld", 128'(core_kld[d]), 128'(0));
      check_eq("rst_core_key", core_key[d], 128'(0));
      check_eq("rst_text_in", core_text_in[d], 128'(0));
      check_eq("rst_busy", 128'(busy[d]), 128'(0));
      check_eq("rst_err", 128'(err[d]), 128'(0));
    end
    rst = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      check_eq("idle_key_ready", 128'(key_ready[d]), 128'(1));
      check_eq("idle_in_ready", 128'(in_ready[d]), 128'(0));
    end

    // Known vectors, then backpressure
    load_key(0, KEY0);
    xfer(0, PT0, 3, 0);
    xfer(0, PT0, 2, 20);
    load_key(1, KEY0);
    xfer(1, CT0, 4, 0);

    // Randomized traffic with occasional re-key
    for (int d = 0; d < 2; d++) begin
      load_key(d, rand128());
      for (int i = 0; i < 8; i++) begin
        if (i == 4) load_key(d, rand128());
        xfer(d, rand128(), int'($urandom_range(1, 6)), int'($urandom_range(0, 4)));
      end
    end

    // Key and block offered together in READY: key wins, block waits
    k2 = rand128();
    b2 = rand128();
    key_in[0] = k2; key_valid[0] = 1'b1;
    in_data[0] = b2; in_valid[0] = 1'b1;
    #1;
    check_eq("kw_in_ready", 128'(in_ready[0]), 128'(0));
    check_eq("kw_key_ready", 128'(key_ready[0]), 128'(1));
    step();
    key_valid[0] = 1'b0;
    key_cur[0]   = k2;
    check_eq("kw_no_ld", 128'(core_ld[0]), 128'(0));
    check_eq("kw_key", core_key[0], k2);
    xfer(0, b2, 2, 0);

    // Core never finishes: watchdog fires
    hang[0] = 1'b1;
    in_data[0] = rand128(); in_valid[0] = 1'b1;
    wait_for(0, S_IRDY, "to_in_ready_wait");
    c = cyc;
    step();
    in_valid[0] = 1'b0;
    wait_for(0, S_ERR, "to_err_wait");
    check_eq("to_err_time", 128'(cyc - c), 128'(66));
    check_eq("to_idle_key_ready", 128'(key_ready[0]), 128'(1));
    check_eq("to_idle_in_ready", 128'(in_ready[0]), 128'(0));
    check_eq("to_busy", 128'(busy[0]), 128'(0));
    hang[0] = 1'b0;
    load_key(0, KEY0);

    // Reset during BUSY: block discarded, late done ignored
    lat[0] = 8;
    in_data[0] = PT0; in_valid[0] = 1'b1;
    wait_for(0, S_IRDY, "rb_in_ready_wait");
    step();
    in_valid[0] = 1'b0;
    step();
    step();
    check_eq("rb_busy_before", 128'(busy[0]), 128'(1));
    rst = 1'b1;
    step();
    check_eq("rb_key_ready_in_rst", 128'(key_ready[0]), 128'(0));
    check_eq("rb_busy", 128'(busy[0]), 128'(0));
    check_eq("rb_text_in", core_text_in[0], 128'(0));
    rst = 1'b0;
    step();
    check_eq("rb_idle_key_ready", 128'(key_ready[0]), 128'(1));
    check_eq("rb_idle_in_ready", 128'(in_ready[0]), 128'(0));
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid[0]) seen = 1'b1;
    end
    check_eq("rb_no_out_valid", 128'(seen), 128'(0));
    check_eq("rb_out_data", out_data[0], 128'(0));
    check_eq("rb_err", 128'(err[0]), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
